mem_port_arbiter: RTL and testbench

- Shares one simple valid/ready memory port (request channel plus response channel) between NR_REQ requesters, e.g. IFU=0 and LSU=1 in the NPC core.
- Grants exactly one requester per transaction.
- Steers that requester's request fields downstream through key-indexed selection, and routes the response back to it only.
- Round-robin fairness by default. Grant is held from request acceptance until the response handshake completes.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_picker.sv | 36 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state encoding and grant-index width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner search over the request vector, starting at a rotating pointer.
// Build option: ARB_FIXED_PRIO_EN selects plain lowest-index priority and drops the pointer port.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NR_REQ = 2,
  parameter int IDX_W  = idx_width(NR_REQ)
) (
  input  logic [NR_REQ-1:0] i_req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]  i_ptr,
`endif
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
  always_comb begin
    o_hit = |i_req;
    o_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int j = NR_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) o_idx = IDX_W'(j);
    end
`else
    // Downward scans keep the lowest match; the at-or-above-pointer pass runs last so it wins.
    for (int j = NR_REQ - 1; j >= 0; j--) begin
      if (i_req[j] && (j < int'(i_ptr))) o_idx = IDX_W'(j);
    end
    for (int j = NR_REQ - 1; j >= 0; j--) begin
      if (i_req[j] && (j >= int'(i_ptr))) o_idx = IDX_W'(j);
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between NR_REQ requesters; grant held request-to-response.
// Build option: ARB_FIXED_PRIO_EN replaces round-robin with fixed priority (requester 0 highest).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NR_REQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          req_valid,
  output logic [NR_REQ-1:0]          req_ready,
  input  logic [NR_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NR_REQ-1:0]          req_wen,
  input  logic [NR_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NR_REQ*DATA_W/8-1:0] req_wmask,
  output logic [NR_REQ-1:0]          resp_valid,
  input  logic [NR_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_wen,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wmask,
  input  logic                       mem_resp_valid,
  output logic                       mem_resp_ready,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDX_W  = idx_width(NR_REQ);
  localparam int MASK_W = DATA_W / 8;

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_grant;
  logic              w_hit;
  logic [IDX_W-1:0]  w_winner;
  logic              w_resp_hs;

  logic [ADDR_W-1:0] w_addr  [NR_REQ];
  logic              w_wen   [NR_REQ];
  logic [DATA_W-1:0] w_wdata [NR_REQ];
  logic [MASK_W-1:0] w_wmask [NR_REQ];

  // Per-requester views of the flattened buses, selected below by grant.
  for (genvar g = 0; g < NR_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wen[g]   = req_wen[g];
    assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    assign w_wmask[g] = req_wmask[g*MASK_W +: MASK_W];
  end

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_rr_ptr;
`endif

  mem_port_arbiter_rr_picker #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .i_req (req_valid),
`ifndef ARB_FIXED_PRIO_EN
    .i_ptr (r_rr_ptr),
`endif
    .o_hit (w_hit),
    .o_idx (w_winner)
  );

  assign w_resp_hs = mem_resp_valid && resp_ready[r_grant];

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_grant <= w_winner;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (w_resp_hs) begin
`ifndef ARB_FIXED_PRIO_EN
            r_rr_ptr <= (r_grant == IDX_W'(NR_REQ - 1)) ? '0 : r_grant + 1'b1;
`endif
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; everything is zero outside the phase that owns it.
  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    resp_rdata     = '0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    mem_resp_ready = 1'b0;
    case (r_state)
      REQ: begin
        mem_req_valid      = 1'b1;
        mem_addr           = w_addr[r_grant];
        mem_wen            = w_wen[r_grant];
        mem_wdata          = w_wdata[r_grant];
        mem_wmask          = w_wmask[r_grant];
        req_ready[r_grant] = mem_req_ready;
      end
      WAIT: begin
        resp_valid[r_grant] = mem_resp_valid;
        resp_rdata          = mem_rdata;
        mem_resp_ready      = resp_ready[r_grant];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NR_REQ=2); expectations follow ARB_FIXED_PRIO_EN when defined.
module tb_mem_port_arbiter;

  localparam int NR_REQ = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NR_REQ-1:0]        req_valid, req_ready, req_wen, resp_valid, resp_ready;
  logic [NR_REQ*ADDR_W-1:0] req_addr;
  logic [NR_REQ*DATA_W-1:0] req_wdata;
  logic [NR_REQ*MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0]        resp_rdata, mem_wdata, mem_rdata;
  logic                     mem_req_valid, mem_req_ready, mem_wen;
  logic                     mem_resp_valid, mem_resp_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MASK_W-1:0]        mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NR_REQ (NR_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    req_valid      = '0;
    req_wen        = '0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wmask      = '0;
    resp_ready     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one complete transaction for requester who, starting from IDLE.
  task automatic drive_txn(input int who);
    int k;
    @(negedge clk);
    req_valid     = NR_REQ'(1) << who;
    mem_req_ready = 1'b1;
    resp_ready    = '1;
    k = 0;
    #1;
    while (req_ready[who] !== 1'b1 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    n_checks++;
    if (k >= 10) begin n_fail++; $display("FAIL txn_req_timeout: requester %0d never accepted", who); end
    @(negedge clk);
    req_valid      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    k = 0;
    #1;
    while (resp_valid[who] !== 1'b1 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    n_checks++;
    if (k >= 10) begin n_fail++; $display("FAIL txn_resp_timeout: requester %0d never answered", who); end
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    req_valid      = 2'b11;
    req_wen        = 2'b00;
    req_addr       = {32'h0000_2000, 32'h0000_1000};
    req_wdata      = '0;
    req_wmask      = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_FFFF;
    resp_ready     = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, resp_valid, resp_rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready});
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    rst_n          = 1'b1;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_idle: mem_req_valid=%b expected 0", mem_req_valid); end
    @(negedge clk); #1;
    n_checks++;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_grant_valid: mem_req_valid=%b expected 1", mem_req_valid); end
    n_checks++;
    if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL first_grant_addr: got %h expected 00001000", mem_addr); end
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL first_grant_stalled: req_ready=%b expected 00", req_ready); end
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL first_grant_ready: req_ready=%b expected 01", req_ready); end
    @(negedge clk);
    req_valid      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0BAD_F00D;
    #1;
    n_checks++;
    if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL first_resp: resp_valid=%b expected 01", resp_valid); end
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_single_read();
    bit seen_rr1;
    apply_reset();
    req_addr[31:0] = 32'h8000_0000;
    req_wen[0]     = 1'b0;
    req_valid      = 2'b01;
    mem_req_ready  = 1'b1;
    resp_ready     = 2'b11;
    seen_rr1       = 1'b0;
    #1;
    if (req_ready[1]) seen_rr1 = 1'b1;
    @(negedge clk); #1;
    if (req_ready[1]) seen_rr1 = 1'b1;
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL read_req_fields: got %h expected %h", {mem_req_valid, mem_addr, mem_wen}, {1'b1, 32'h8000_0000, 1'b0});
    end
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL read_req_ready: req_ready=%b expected 01", req_ready); end
    @(negedge clk);
    req_valid     = '0;
    mem_req_ready = 1'b0;
    #1;
    if (req_ready[1]) seen_rr1 = 1'b1;
    n_checks++;
    if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL read_resp_early: resp_valid=%b expected 00", resp_valid); end
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({resp_valid, resp_rdata, mem_resp_ready} !== {2'b01, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL read_resp: got %h expected %h", {resp_valid, resp_rdata, mem_resp_ready}, {2'b01, 32'hDEAD_BEEF, 1'b1});
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_rdata, mem_req_valid} !== '0) begin
      n_fail++;
      $display("FAIL read_idle_after: got %h expected 0", {resp_valid, resp_rdata, mem_req_valid});
    end
    n_checks++;
    if (seen_rr1 !== 1'b0) begin n_fail++; $display("FAIL read_no_ready1: req_ready[1] seen=%b expected 0", seen_rr1); end
  endtask

  task automatic test_fairness();
    int          waited;
    int          exp_g;
    logic [31:0] exp_d;
    apply_reset();
    req_addr      = {32'h0000_0200, 32'h0000_0100};
    req_valid     = 2'b11;
    mem_req_ready = 1'b1;
    resp_ready    = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = t % 2;
`endif
      exp_d  = 32'h0000_00A0 + 32'(t);
      waited = 0;
      do begin
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        waited++;
      end while (mem_req_valid !== 1'b1 && waited < 6);
      n_checks++;
      if (waited !== ((t == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL fair_latency[%0d]: cycles to request=%0d expected %0d", t, waited, (t == 0) ? 1 : 2);
      end
      n_checks++;
      if (req_ready !== (NR_REQ'(1) << exp_g)) begin
        n_fail++;
        $display("FAIL fair_grant[%0d]: req_ready=%b expected grant %0d", t, req_ready, exp_g);
      end
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_rdata      = exp_d;
      #1;
      n_checks++;
      if ({resp_valid, resp_rdata} !== {NR_REQ'(1) << exp_g, exp_d}) begin
        n_fail++;
        $display("FAIL fair_resp[%0d]: got %h expected %h", t, {resp_valid, resp_rdata}, {NR_REQ'(1) << exp_g, exp_d});
      end
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    req_valid      = '0;
  endtask

  task automatic test_backpressure();
    int hs_req;
    int hs_resp;
    apply_reset();
    req_addr[63:32]  = 32'h0000_0010;
    req_wen[1]       = 1'b1;
    req_wdata[63:32] = 32'h0000_1234;
    req_wmask[7:4]   = 4'hF;
    req_valid        = 2'b10;
    mem_req_ready    = 1'b0;
    resp_ready       = 2'b00;
    hs_req           = 0;
    hs_resp          = 0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, req_ready} !==
          {1'b1, 32'h0000_0010, 1'b1, 32'h0000_1234, 4'hF, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_req_hold[%0d]: got %h", c, {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, req_ready});
      end
      if (mem_req_valid && mem_req_ready) hs_req++;
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, mem_addr, mem_wdata} !== {2'b10, 32'h0000_0010, 32'h0000_1234}) begin
      n_fail++;
      $display("FAIL bp_req_accept: got %h", {req_ready, mem_addr, mem_wdata});
    end
    if (mem_req_valid && mem_req_ready) hs_req++;
    @(negedge clk);
    req_valid      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h00C0_FFEE;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({resp_valid, mem_resp_ready, resp_rdata, mem_req_valid} !== {2'b10, 1'b0, 32'h00C0_FFEE, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_resp_hold[%0d]: got %h", c, {resp_valid, mem_resp_ready, resp_rdata, mem_req_valid});
      end
      if (mem_resp_valid && mem_resp_ready) hs_resp++;
      if (mem_req_valid && mem_req_ready) hs_req++;
      @(negedge clk);
    end
    resp_ready = 2'b10;
    #1;
    n_checks++;
    if ({resp_valid, mem_resp_ready} !== {2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_resp_accept: got %b expected 101", {resp_valid, mem_resp_ready});
    end
    if (mem_resp_valid && mem_resp_ready) hs_resp++;
    @(negedge clk);
    #1;
    if (mem_resp_valid && mem_resp_ready) hs_resp++;
    mem_resp_valid = 1'b0;
    resp_ready     = '0;
    n_checks++;
    if (hs_req !== 1) begin n_fail++; $display("FAIL bp_req_handshakes: got %0d expected 1", hs_req); end
    n_checks++;
    if (hs_resp !== 1) begin n_fail++; $display("FAIL bp_resp_handshakes: got %0d expected 1", hs_resp); end
  endtask

  task automatic test_spurious();
    apply_reset();
    req_valid      = '0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    resp_ready     = 2'b11;
    repeat (2) begin
      #1;
      n_checks++;
      if ({resp_valid, mem_resp_ready, resp_rdata} !== '0) begin
        n_fail++;
        $display("FAIL spur_idle: got %h expected 0", {resp_valid, mem_resp_ready, resp_rdata});
      end
      @(negedge clk);
    end
    req_addr[31:0] = 32'h0000_0044;
    req_valid      = 2'b01;
    mem_req_ready  = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({mem_req_valid, resp_valid, mem_resp_ready} !== {1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL spur_req: got %b expected 1000", {mem_req_valid, resp_valid, mem_resp_ready});
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid     = '0;
    mem_req_ready = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_rdata} !== {2'b01, 32'h5555_AAAA}) begin
      n_fail++;
      $display("FAIL spur_wait_delivers: got %h expected %h", {resp_valid, resp_rdata}, {2'b01, 32'h5555_AAAA});
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_midop_reset();
    apply_reset();
    drive_txn(0);
    req_addr      = {32'h0000_0020, 32'h0000_0030};
    req_valid     = 2'b10;
    mem_req_ready = 1'b1;
    resp_ready    = 2'b11;
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL midop_req: req_ready=%b expected 10", req_ready); end
    @(negedge clk);
    req_valid      = '0;
    mem_req_ready  = 1'b0;
    resp_ready     = 2'b00;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    #1;
    n_checks++;
    if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL midop_wait: resp_valid=%b expected 10", resp_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, mem_resp_ready, mem_req_valid, resp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got %h expected 0", {resp_valid, mem_resp_ready, mem_req_valid, resp_rdata});
    end
    @(negedge clk);
    rst_n          = 1'b1;
    mem_resp_valid = 1'b0;
    req_valid      = 2'b11;
    resp_ready     = 2'b11;
    @(negedge clk); #1;
    n_checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0000_0030}) begin
      n_fail++;
      $display("FAIL midop_ptr_cleared: got %h expected %h", {mem_req_valid, mem_addr}, {1'b1, 32'h0000_0030});
    end
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midop_regrant: req_ready=%b expected 01", req_ready); end
    @(negedge clk);
    req_valid     = '0;
    mem_req_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_backpressure();
    test_spurious();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
